// File: rtl/gray_frame_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_frame_writer_pkg: state encoding and pixel width shared by the  |
// | gray pixel path.                              Rev 1.0 initial release |
// +----------------------------------------------------------------------+
package gray_frame_writer_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/gray_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_fifo: synchronous FIFO, read data registered on pop.            |
// |                                               Rev 1.0 initial release |
// +----------------------------------------------------------------------+
module gray_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = dout_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    dout_d   = do_pop  ? mem_q[rd_ptr_q] : dout_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gray_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_frame_writer: buffers a gray pixel stream and writes one frame  |
// | in raster order to a BRAM port. Optional: THRESHOLD_EN binarises.    |
// |                                               Rev 1.0 initial release |
// +----------------------------------------------------------------------+
module gray_frame_writer
  import gray_frame_writer_pkg::*;
#(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int THRESH     = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pix_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  output logic              busy,
  output logic              frame_done
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(TOTAL + 1);

`ifdef THRESHOLD_EN
  localparam bit THR_ON = 1'b1;
`else
  localparam bit THR_ON = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  accept_cnt_q, accept_cnt_d;
  logic [CNT_W-1:0]  write_cnt_q, write_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PIX_W-1:0]  fifo_din;
  logic [PIX_W-1:0]  fifo_dout;

  assign pix_ready  = (state_q == ST_WRITE) && !fifo_full &&
                      (accept_cnt_q < CNT_W'(TOTAL));
  assign fifo_push  = pix_valid && pix_ready;
  assign fifo_pop   = (state_q == ST_WRITE) && !fifo_empty;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = fifo_dout;

  // Binarising before the FIFO keeps the popped word directly usable as write data.
  always_comb begin
    fifo_din = pix_data;
    if (THR_ON) begin
      fifo_din = (32'(pix_data) >= THRESH) ? '1 : '0;
    end
  end

  always_comb begin
    state_d      = state_q;
    accept_cnt_d = accept_cnt_q;
    write_cnt_d  = write_cnt_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_WRITE;
          accept_cnt_d = '0;
          write_cnt_d  = '0;
        end
      end
      ST_WRITE: begin
        if (fifo_push) begin
          accept_cnt_d = accept_cnt_q + CNT_W'(1);
        end
        if (fifo_pop) begin
          write_cnt_d = write_cnt_q + CNT_W'(1);
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(write_cnt_q);
        end
        if (write_cnt_q == CNT_W'(TOTAL)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      accept_cnt_q <= '0;
      write_cnt_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      accept_cnt_q <= accept_cnt_d;
      write_cnt_q  <= write_cnt_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  gray_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_gray_frame_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gray_frame_writer: self-checking bench for gray_frame_writer.     |
// |                                               Rev 1.0 initial release |
// +----------------------------------------------------------------------+
module tb_gray_frame_writer;

  localparam int IMG_W      = 4;
  localparam int IMG_H      = 2;
  localparam int ADDR_W     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int THRESH     = 128;
  localparam int TOTAL      = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              pix_valid;
  logic [7:0]        pix_data;
  logic              pix_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              frame_done;

  gray_frame_writer #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .THRESH     (THRESH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] pix;
    int         addr;
    int         data;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         got_addr[$];
  int         got_data[$];
  int         got_cyc[$];
  int         done_cnt;
  int         done_cyc;
  int         xfer_cnt;
  int         first_xfer_cyc;
  int         ready_late;
  logic [7:0] pix_buf[16];
  vec_t       tbl[TOTAL];

  // Reference: each stored word is the accepted pixel, binarised when enabled.
  function automatic int model_pix(input int p);
`ifdef THRESHOLD_EN
    return (p >= THRESH) ? 255 : 0;
`else
    return p;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mem_we) begin
      got_addr.push_back(int'(mem_addr));
      got_data.push_back(int'(mem_wdata));
      got_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pix_ready"},  int'(pix_ready),  0);
    check({tag, "_mem_we"},     int'(mem_we),     0);
    check({tag, "_mem_addr"},   int'(mem_addr),   0);
    check({tag, "_mem_wdata"},  int'(mem_wdata),  0);
    check({tag, "_busy"},       int'(busy),       0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
  endtask

  // mode 0: valid held high, 1: valid toggles, 2: random valid.
  task automatic run_frame(input int n_offer, input int mode, input bit mid_start);
    int idx = 0;
    bit toggle = 1'b1;
    bit start_sent = 1'b0;
    int done_before = done_cnt;
    xfer_cnt       = 0;
    first_xfer_cyc = -1;
    ready_late     = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (done_cnt != done_before) break;
      start = 1'b0;
      if (idx < n_offer) begin
        pix_data = pix_buf[idx];
        case (mode)
          0:       pix_valid = 1'b1;
          1:       begin pix_valid = toggle; toggle = ~toggle; end
          default: pix_valid = 1'($urandom_range(0, 1));
        endcase
      end else begin
        pix_valid = 1'b0;
      end
      if (xfer_cnt >= TOTAL && pix_ready) ready_late++;
      if (mid_start && !start_sent && xfer_cnt == 3) begin
        start      = 1'b1;
        start_sent = 1'b1;
      end
      if (pix_valid && pix_ready) begin
        if (xfer_cnt == 0) first_xfer_cyc = cyc;
        xfer_cnt++;
        idx++;
      end
    end
    start = 1'b0;
    check("frame_done_seen", done_cnt - done_before, 1);
    check("busy_in_done", int'(busy), 1);
    tick();
    check("busy_after_done", int'(busy), 0);
    check("ready_after_done", int'(pix_ready), 0);
    tick();
    pix_valid = 1'b0;
    check("frame_done_once", done_cnt - done_before, 1);
    check("accepted_count", xfer_cnt, TOTAL);
    check("ready_after_total", ready_late, 0);
    check("write_count", got_addr.size(), TOTAL);
    if (got_cyc.size() == TOTAL) begin
      check("done_after_last_write", done_cyc, got_cyc[TOTAL-1] + 1);
      if (mode == 0) begin
        check("first_write_latency", got_cyc[0] - first_xfer_cyc, 2);
        check("sustained_rate", got_cyc[TOTAL-1] - got_cyc[0], TOTAL - 1);
      end
      if (mode == 1) begin
        check("toggle_has_gaps", int'(got_cyc[TOTAL-1] - got_cyc[0] > TOTAL - 1), 1);
      end
    end
  endtask

  task automatic check_writes(input string tag);
    for (int i = 0; i < TOTAL; i++) begin
      if (i < got_addr.size()) begin
        check({tag, "_addr"}, got_addr[i], i);
        check({tag, "_data"}, got_data[i], model_pix(int'(pix_buf[i])));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int idle_ready;
    int idx;
    logic [7:0] thr_pix[TOTAL];
    rst       = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = 8'h00;
    clear_log();
    repeat (2) tick();
    check_idle_outputs("reset");
    rst = 1'b0;

    // Offers while idle must be refused and never written.
    pix_valid  = 1'b1;
    pix_data   = 8'h55;
    idle_ready = 0;
    repeat (4) begin
      tick();
      if (pix_ready) idle_ready++;
    end
    pix_valid = 1'b0;
    check("idle_ready", idle_ready, 0);
    check("idle_writes", got_addr.size(), 0);

    // Back-to-back frame of 0x10..0x17 plus a ninth pixel that must stay pending.
    for (int i = 0; i < TOTAL; i++) begin
      tbl[i].pix  = 8'h10 + 8'(i);
      tbl[i].addr = i;
      tbl[i].data = model_pix(int'(tbl[i].pix));
      pix_buf[i]  = tbl[i].pix;
    end
    pix_buf[TOTAL] = 8'h99;
    clear_log();
    pulse_start();
    run_frame(TOTAL + 1, 0, 1'b0);
    for (int i = 0; i < TOTAL; i++) begin
      if (i < got_addr.size()) begin
        check("b2b_addr", got_addr[i], tbl[i].addr);
        check("b2b_data", got_data[i], tbl[i].data);
      end
    end

    // Same pixels with valid toggling every cycle.
    clear_log();
    pulse_start();
    run_frame(TOTAL, 1, 1'b0);
    check_writes("toggle");

    // Random data and valid, with a stray start pulse mid-frame.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < TOTAL; i++) pix_buf[i] = 8'($urandom_range(0, 255));
      clear_log();
      pulse_start();
      run_frame(TOTAL, 2, 1'b1);
      check_writes("random");
    end

    // Reset after three writes aborts the frame.
    for (int i = 0; i < TOTAL; i++) pix_buf[i] = 8'h20 + 8'(i);
    clear_log();
    pulse_start();
    idx = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (got_addr.size() >= 3) break;
      pix_data  = pix_buf[idx];
      pix_valid = 1'b1;
      if (pix_ready) idx++;
    end
    check("pre_reset_writes", got_addr.size(), 3);
    rst       = 1'b1;
    pix_valid = 1'b0;
    tick();
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    repeat (4) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_no_writes", got_addr.size(), 3);
    check_writes("abort");

    for (int i = 0; i < TOTAL; i++) pix_buf[i] = 8'h30 + 8'(i);
    clear_log();
    pulse_start();
    run_frame(TOTAL, 0, 1'b0);
    check_writes("restart");

    // Threshold boundary pixels, table driven.
    thr_pix = '{8'h7F, 8'h80, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h01, 8'hFE};
    for (int i = 0; i < TOTAL; i++) begin
      tbl[i].pix  = thr_pix[i];
      tbl[i].addr = i;
      tbl[i].data = model_pix(int'(thr_pix[i]));
      pix_buf[i]  = thr_pix[i];
    end
    clear_log();
    pulse_start();
    run_frame(TOTAL, 0, 1'b0);
    for (int i = 0; i < TOTAL; i++) begin
      if (i < got_addr.size()) begin
        check("thr_addr", got_addr[i], tbl[i].addr);
        check("thr_data", got_data[i], tbl[i].data);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
